spi_slave_to_ctrlport_master: RTL

- SPI target (CPLD side) for the 64-bit ctrlport-over-SPI frame; converts each frame into one ctrlport request on the local register bus and returns data, ack and status in the same frame.
- Instantiated in the MB and DB CPLDs, behind the FPGA-side SPI initiator.
- SPI inputs are oversampled and synchronized into ctrlport_clk; there is no sclk-domain logic.

---
 rtl/spi_slave_to_ctrlport_master_if.sv | 32 +++
 rtl/spi_slave_to_ctrlport_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_to_ctrlport_master_if.sv
// ---------------------------------------------------------------------------
// spi_slave_to_ctrlport_master_if
// Local ctrlport request/response bundle between the SPI target and the
// register bus.
//   m_ctrlport_req_wr       one-cycle write request strobe
//   m_ctrlport_req_rd       one-cycle read request strobe
//   m_ctrlport_req_addr     request address (20 bits)
//   m_ctrlport_req_data     write data (32 bits)
//   m_ctrlport_resp_ack     response strobe
//   m_ctrlport_resp_status  response status (2 bits)
//   m_ctrlport_resp_data    read data (32 bits)
// Modports: master (drives requests), slave (drives responses).
// ---------------------------------------------------------------------------
interface spi_slave_to_ctrlport_master_if;
  logic        m_ctrlport_req_wr;
  logic        m_ctrlport_req_rd;
  logic [19:0] m_ctrlport_req_addr;
  logic [31:0] m_ctrlport_req_data;
  logic        m_ctrlport_resp_ack;
  logic [1:0]  m_ctrlport_resp_status;
  logic [31:0] m_ctrlport_resp_data;

  modport master (
    output m_ctrlport_req_wr, m_ctrlport_req_rd, m_ctrlport_req_addr, m_ctrlport_req_data,
    input  m_ctrlport_resp_ack, m_ctrlport_resp_status, m_ctrlport_resp_data
  );

  modport slave (
    input  m_ctrlport_req_wr, m_ctrlport_req_rd, m_ctrlport_req_addr, m_ctrlport_req_data,
    output m_ctrlport_resp_ack, m_ctrlport_resp_status, m_ctrlport_resp_data
  );
endinterface

// File: rtl/spi_slave_to_ctrlport_master.sv
// ---------------------------------------------------------------------------
// spi_slave_to_ctrlport_master
// SPI target that turns each 64-bit SPI frame into one ctrlport request and
// returns read data, ack and status within the same frame. SPI pins are
// oversampled in ctrlport_clk; there is no sclk-domain logic.
// Ports:
//   ctrlport_clk_i  sole clock
//   ctrlport_rst_i  asynchronous reset, active-high
//   ss_i            SPI select, active-low
//   sclk_i          SPI clock, idle low
//   mosi_i          serial data in (MSB first)
//   miso_o          serial data out
//   err_count_o     failed/aborted frame count (only with SPI_SLAVE_ERR_COUNT_EN)
//   ctrlport        request/response bundle (master modport)
// Optional feature macro: SPI_SLAVE_ERR_COUNT_EN
//
// state     | meaning
// IDLE      | ss high, waiting for ss falling edge
// SHIFT_IN  | collecting command/address (and write data)
// REQ       | issue request, or fail the frame if one is still unanswered
// WAIT_RESP | waiting for resp_ack until the miso deadline
// SHIFT_OUT | launching data/ack/status on miso
// ---------------------------------------------------------------------------
module spi_slave_to_ctrlport_master #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [19:0] BASE_ADDRESS = 20'h0
) (
  input  logic ctrlport_clk_i,
  input  logic ctrlport_rst_i,
  input  logic ss_i,
  input  logic sclk_i,
  input  logic mosi_i,
  output logic miso_o,
`ifdef SPI_SLAVE_ERR_COUNT_EN
  output logic [15:0] err_count_o,
`endif
  spi_slave_to_ctrlport_master_if.master ctrlport
);

  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {IDLE, SHIFT_IN, REQ, WAIT_RESP, SHIFT_OUT} state_t;

  state_t            state_q;
  logic [STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic              ss_prev_q, sclk_prev_q;
  logic [6:0]        cnt_q;
  logic              wr_q;
  logic [14:0]       addr_q;
  logic [31:0]       rx_q;
  logic              outstanding_q;
  logic              ack_bit_q;
  logic [1:0]        status_q;
  logic [31:0]       rdata_q;
  logic              miso_q;
  logic              req_wr_q, req_rd_q;
  logic [19:0]       req_addr_q;
  logic [31:0]       req_data_q;
`ifdef SPI_SLAVE_ERR_COUNT_EN
  logic [15:0]       err_cnt_q;
`endif

  logic ss_s, sclk_s, mosi_s;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;

  assign ss_s      = ss_sync_q[STAGES-1];
  assign sclk_s    = sclk_sync_q[STAGES-1];
  assign mosi_s    = mosi_sync_q[STAGES-1];
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // miso value for wire bit n: read data on 24..55, ack on 61, status on 62..63.
  function automatic logic tx_bit(input logic [6:0] n, input logic rd, input logic [31:0] d,
                                  input logic ack, input logic [1:0] st);
    logic [31:0] sh;
    logic        b;
    b  = 1'b0;
    sh = d << (n - 7'd24);
    if (rd && n >= 7'd24 && n <= 7'd55) b = sh[31];
    else if (n == 7'd61)                b = ack;
    else if (n == 7'd62)                b = st[1];
    else if (n == 7'd63)                b = st[0];
    return b;
  endfunction

  always_ff @(posedge ctrlport_clk_i or posedge ctrlport_rst_i) begin
    if (ctrlport_rst_i) begin
      state_q       <= IDLE;
      ss_sync_q     <= '0;
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      ss_prev_q     <= 1'b0;
      sclk_prev_q   <= 1'b0;
      cnt_q         <= 7'd0;
      wr_q          <= 1'b0;
      addr_q        <= 15'd0;
      rx_q          <= 32'd0;
      outstanding_q <= 1'b0;
      ack_bit_q     <= 1'b0;
      status_q      <= 2'd0;
      rdata_q       <= 32'd0;
      miso_q        <= 1'b0;
      req_wr_q      <= 1'b0;
      req_rd_q      <= 1'b0;
      req_addr_q    <= 20'd0;
      req_data_q    <= 32'd0;
`ifdef SPI_SLAVE_ERR_COUNT_EN
      err_cnt_q     <= 16'd0;
`endif
    end else begin
      ss_sync_q   <= {ss_sync_q[STAGES-2:0], ss_i};
      sclk_sync_q <= {sclk_sync_q[STAGES-2:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[STAGES-2:0], mosi_i};
      ss_prev_q   <= ss_s;
      sclk_prev_q <= sclk_s;
      req_wr_q    <= 1'b0;
      req_rd_q    <= 1'b0;

      // Any ack answers the single outstanding request; outside WAIT_RESP
      // its payload is simply dropped.
      if (ctrlport.m_ctrlport_resp_ack && outstanding_q) outstanding_q <= 1'b0;

      // Bit index saturates at 64 so trailing clocks are ignored.
      if (state_q != IDLE && sclk_rise && cnt_q != 7'd64) cnt_q <= cnt_q + 7'd1;

      if (ss_rise && state_q != IDLE) begin
        state_q <= IDLE;
        miso_q  <= 1'b0;
`ifdef SPI_SLAVE_ERR_COUNT_EN
        if ((state_q != SHIFT_OUT || !ack_bit_q || cnt_q != 7'd64) && err_cnt_q != 16'hFFFF)
          err_cnt_q <= err_cnt_q + 16'd1;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            miso_q <= 1'b0;
            if (ss_fall) begin
              state_q <= SHIFT_IN;
              cnt_q   <= 7'd0;
            end
          end
          SHIFT_IN: begin
            if (sclk_fall) miso_q <= 1'b0;
            if (sclk_rise) begin
              rx_q <= {rx_q[30:0], mosi_s};
              if (cnt_q == 7'd0) wr_q <= mosi_s;
              if (cnt_q == 7'd15) begin
                addr_q <= {rx_q[13:0], mosi_s};
                if (!wr_q) state_q <= REQ;
              end
              if (cnt_q == 7'd47) state_q <= REQ;
            end
          end
          REQ: begin
            if (outstanding_q) begin
              ack_bit_q <= 1'b0;
              status_q  <= 2'd0;
              rdata_q   <= 32'd0;
              state_q   <= SHIFT_OUT;
            end else begin
              req_wr_q      <= wr_q;
              req_rd_q      <= ~wr_q;
              req_addr_q    <= BASE_ADDRESS + {5'd0, addr_q};
              if (wr_q) req_data_q <= rx_q;
              outstanding_q <= 1'b1;
              state_q       <= WAIT_RESP;
            end
          end
          WAIT_RESP: begin
            if (ctrlport.m_ctrlport_resp_ack) begin
              rdata_q   <= ctrlport.m_ctrlport_resp_data;
              status_q  <= ctrlport.m_ctrlport_resp_status;
              ack_bit_q <= 1'b1;
              state_q   <= SHIFT_OUT;
              // An ack landing on the deadline edge must still launch its bit.
              if (sclk_fall)
                miso_q <= tx_bit(cnt_q, ~wr_q, ctrlport.m_ctrlport_resp_data, 1'b1,
                                 ctrlport.m_ctrlport_resp_status);
            end else if (sclk_fall) begin
              miso_q <= 1'b0;
              if (cnt_q == (wr_q ? 7'd61 : 7'd24)) begin
                ack_bit_q <= 1'b0;
                status_q  <= 2'd0;
                rdata_q   <= 32'd0;
                state_q   <= SHIFT_OUT;
              end
            end
          end
          SHIFT_OUT: begin
            if (sclk_fall) miso_q <= tx_bit(cnt_q, ~wr_q, rdata_q, ack_bit_q, status_q);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign miso_o                       = miso_q;
  assign ctrlport.m_ctrlport_req_wr   = req_wr_q;
  assign ctrlport.m_ctrlport_req_rd   = req_rd_q;
  assign ctrlport.m_ctrlport_req_addr = req_addr_q;
  assign ctrlport.m_ctrlport_req_data = req_data_q;
`ifdef SPI_SLAVE_ERR_COUNT_EN
  assign err_count_o = err_cnt_q;
`endif

endmodule
